// File: rtl/alu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | alu_pkg : state encoding, default sizes and clog2 helper for the ALU  |
// | Revision: 1.0                                                         |
// +------------------------------------------------------------------------+
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CHUNK = 8;

  // Ceiling log2 with a floor of 1 so a single-chunk counter still has a bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cla_chunk.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | cla_chunk : combinational CHUNK-bit carry-lookahead adder slice       |
// | Revision: 1.0                                                         |
// +------------------------------------------------------------------------+
module cla_chunk
  import alu_pkg::*;
#(
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK-1:0] w_g;
  logic [CHUNK-1:0] w_p;
  logic [CHUNK:0]   w_c;
  logic             w_acc;
  logic             w_pp;

  assign w_g = x & y;
  assign w_p = x ^ y;

  // Each carry is the flattened sum-of-products over all lower generate
  // terms, so no carry depends on another carry.
  always_comb begin
    w_c    = '0;
    w_c[0] = cin;
    w_acc  = 1'b0;
    w_pp   = 1'b1;
    for (int i = 0; i < CHUNK; i++) begin
      w_acc = 1'b0;
      w_pp  = 1'b1;
      for (int j = i; j >= 0; j--) begin
        w_acc = w_acc | (w_pp & w_g[j]);
        w_pp  = w_pp & w_p[j];
      end
      w_c[i+1] = w_acc | (w_pp & cin);
    end
  end

  assign s     = w_p ^ w_c[CHUNK-1:0];
  assign cout  = w_c[CHUNK];
  assign c_msb = w_c[CHUNK-1];

endmodule
`default_nettype wire

// File: rtl/chunked_add_sub_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | chunked_add_sub_unit : multi-cycle A+B / A-B, CHUNK bits per clock    |
// | Revision: 1.0                                                         |
// +------------------------------------------------------------------------+
module chunked_add_sub_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = clog2(NCHUNK);

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic             carry_q;
  logic [IDXW-1:0]  idx_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  logic [CHUNK-1:0] w_x;
  logic [CHUNK-1:0] w_y;
  logic [CHUNK-1:0] w_s;
  logic             w_cout;
  logic             w_cmsb;
  logic             w_last;

  assign w_last = (idx_q == IDXW'(NCHUNK - 1));

  always_comb begin
    w_x = '0;
    w_y = '0;
    for (int n = 0; n < NCHUNK; n++) begin
      if (idx_q == IDXW'(n)) begin
        w_x = a_q[n*CHUNK +: CHUNK];
        w_y = b_q[n*CHUNK +: CHUNK];
      end
    end
  end

  cla_chunk #(.CHUNK(CHUNK)) u_cla (
    .x     (w_x),
    .y     (w_y),
    .cin   (carry_q),
    .s     (w_s),
    .cout  (w_cout),
    .c_msb (w_cmsb)
  );

  always_comb begin
    sum_d = sum_q;
    for (int n = 0; n < NCHUNK; n++) begin
      if (idx_q == IDXW'(n)) sum_d[n*CHUNK +: CHUNK] = w_s;
    end
  end

  // B is stored pre-inverted and the carry seeded with sub, so subtraction
  // is just A + ~B + 1 through the same adder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b ^ {WIDTH{sub}};
            carry_q <= sub;
            sum_q   <= '0;
            idx_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          sum_q   <= sum_d;
          carry_q <= w_cout;
          idx_q   <= idx_q + 1'b1;
          if (w_last) begin
            cout_q  <= w_cout;
            ovf_q   <= w_cmsb ^ w_cout;
            zero_q  <= (sum_d == '0);
            idx_q   <= '0;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
`default_nettype wire
